// File: rtl/noc_packetizer.sv
// noc_packetizer: injection-side NoC endpoint adapter.
// Accepts a whole multi-flit message over valid/ready, serializes it into
// flits toward one router local input port, and mirrors that port's input
// buffer with a credit counter so no flit is sent without a free slot.
module noc_packetizer #(
    parameter int DEST_WIDTH        = 4,
    parameter int FLIT_WIDTH        = 256,
    parameter int FLIT_BUFFER_DEPTH = 2,
    parameter int PACKET_FLITS      = 4,
    localparam int LW = $clog2(PACKET_FLITS + 1),
    localparam int CW = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [FLIT_WIDTH*PACKET_FLITS-1:0] msg_data,
    input  logic [DEST_WIDTH-1:0]              msg_dest,
    input  logic [LW-1:0]                      msg_len,
    input  logic                               msg_valid,
    output logic                               msg_ready,
    output logic [FLIT_WIDTH-1:0]              data_out,
    output logic [DEST_WIDTH-1:0]              dest_out,
    output logic                               is_tail_out,
    output logic                               send_out,
    input  logic                               credit_in,
    output logic                               busy,
    output logic                               credit_overflow
);

    localparam logic [LW-1:0] MAX_LEN     = LW'(PACKET_FLITS);
    localparam logic [CW-1:0] MAX_CREDITS = CW'(FLIT_BUFFER_DEPTH);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t                             state;
    logic [FLIT_WIDTH*PACKET_FLITS-1:0] msg_buf;
    logic [DEST_WIDTH-1:0]              dest;
    logic [LW-1:0]                      len;
    logic [LW-1:0]                      idx;
    logic [CW-1:0]                      credits;
    logic [LW-1:0]                      eff_len;
    logic                               fire;
    logic                               last;
    logic                               accept;

    // A flit goes out whenever a message is held and the router has a free slot
    assign fire   = (state == SEND) && (credits != '0);
    assign last   = (idx == len - LW'(1));
    assign accept = msg_valid && msg_ready;

    // The next message may enter on the same edge the current tail leaves
    assign msg_ready   = (state == IDLE) || (fire && last);
    assign send_out    = fire;
    assign is_tail_out = fire && last;
    assign busy        = (state == SEND);
    assign dest_out    = dest;

    // Length normalisation: 0 means one flit, oversize clamps to the buffer size
    always_comb begin
        eff_len = msg_len;
        if (msg_len == '0) begin
            eff_len = LW'(1);
        end else if (msg_len > MAX_LEN) begin
            eff_len = MAX_LEN;
        end
    end

    // Select the current flit out of the held message
    always_comb begin
        data_out = '0;
        for (int unsigned k = 0; k < PACKET_FLITS; k++) begin
            if (idx == LW'(k)) begin
                data_out = msg_buf[k*FLIT_WIDTH +: FLIT_WIDTH];
            end
        end
    end

    // Message FSM: load on accept, step the flit index on each fire, reload at the tail
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            msg_buf <= '0;
            dest    <= '0;
            len     <= LW'(1);
            idx     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        msg_buf <= msg_data;
                        dest    <= msg_dest;
                        len     <= eff_len;
                        idx     <= '0;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    if (fire) begin
                        if (!last) begin
                            idx <= idx + LW'(1);
                        end else if (accept) begin
                            msg_buf <= msg_data;
                            dest    <= msg_dest;
                            len     <= eff_len;
                            idx     <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Credit counter mirroring the router input buffer; a return into a full counter is flagged
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            credits         <= MAX_CREDITS;
            credit_overflow <= 1'b0;
        end else begin
            case ({fire, credit_in})
                2'b10: credits <= credits - CW'(1);
                2'b01: begin
                    if (credits == MAX_CREDITS) begin
                        credit_overflow <= 1'b1;
                    end else begin
                        credits <= credits + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_noc_packetizer.sv
// Directed testbench for noc_packetizer with default parameters
// (4-bit dest, 256-bit flits, 2 credits, 4 flits per message).
module tb_noc_packetizer;

    localparam int DW = 4;
    localparam int FW = 256;
    localparam int PF = 4;
    localparam int LW = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [FW*PF-1:0] msg_data;
    logic [DW-1:0]    msg_dest;
    logic [LW-1:0]    msg_len;
    logic             msg_valid;
    logic             msg_ready;
    logic [FW-1:0]    data_out;
    logic [DW-1:0]    dest_out;
    logic             is_tail_out;
    logic             send_out;
    logic             credit_in;
    logic             busy;
    logic             credit_overflow;

    int vectors = 0;
    int miscompares = 0;

    logic [FW-1:0] exp_flit;

    noc_packetizer #(
        .DEST_WIDTH(DW),
        .FLIT_WIDTH(FW),
        .FLIT_BUFFER_DEPTH(2),
        .PACKET_FLITS(PF)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .msg_data(msg_data),
        .msg_dest(msg_dest),
        .msg_len(msg_len),
        .msg_valid(msg_valid),
        .msg_ready(msg_ready),
        .data_out(data_out),
        .dest_out(dest_out),
        .is_tail_out(is_tail_out),
        .send_out(send_out),
        .credit_in(credit_in),
        .busy(busy),
        .credit_overflow(credit_overflow)
    );

    always #5 clk = ~clk;

    // Distinct, recognisable flit pattern per (message tag, flit index)
    function automatic logic [FW-1:0] fv(input int unsigned tag, input int unsigned k);
        return {8{32'hF1F0_0000 | 32'(tag * 16 + k)}};
    endfunction

    function automatic logic [FW*PF-1:0] mk(input int unsigned tag);
        logic [FW*PF-1:0] m;
        for (int unsigned k = 0; k < PF; k++) m[k*FW +: FW] = fv(tag, k);
        return m;
    endfunction

    task automatic test_reset;
        rst_n = 1'b0; msg_valid = 1'b0; credit_in = 1'b0;
        msg_len = '0; msg_dest = '0; msg_data = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++; if (send_out !== 1'b0) begin miscompares++; $display("FAIL reset.send_out got %b want 0", send_out); end
        vectors++; if (is_tail_out !== 1'b0) begin miscompares++; $display("FAIL reset.is_tail_out got %b want 0", is_tail_out); end
        vectors++; if (data_out !== '0) begin miscompares++; $display("FAIL reset.data_out got %h want 0", data_out); end
        vectors++; if (dest_out !== '0) begin miscompares++; $display("FAIL reset.dest_out got %h want 0", dest_out); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset.busy got %b want 0", busy); end
        vectors++; if (msg_ready !== 1'b1) begin miscompares++; $display("FAIL reset.msg_ready got %b want 1", msg_ready); end
        vectors++; if (credit_overflow !== 1'b0) begin miscompares++; $display("FAIL reset.credit_overflow got %b want 0", credit_overflow); end
    endtask

    task automatic test_single;
        msg_data = '0; msg_data[7:0] = 8'hA5;
        msg_dest = 4'd3; msg_len = 3'd1; msg_valid = 1'b1;
        vectors++; if (msg_ready !== 1'b1) begin miscompares++; $display("FAIL single.ready_idle got %b want 1", msg_ready); end
        @(negedge clk);
        msg_valid = 1'b0;
        exp_flit = '0; exp_flit[7:0] = 8'hA5;
        vectors++; if (send_out !== 1'b1) begin miscompares++; $display("FAIL single.send got %b want 1", send_out); end
        vectors++; if (is_tail_out !== 1'b1) begin miscompares++; $display("FAIL single.tail got %b want 1", is_tail_out); end
        vectors++; if (data_out !== exp_flit) begin miscompares++; $display("FAIL single.data got %h want %h", data_out, exp_flit); end
        vectors++; if (dest_out !== 4'd3) begin miscompares++; $display("FAIL single.dest got %h want 3", dest_out); end
        @(negedge clk);
        vectors++; if (send_out !== 1'b0) begin miscompares++; $display("FAIL single.send_after got %b want 0", send_out); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single.busy_after got %b want 0", busy); end
        vectors++; if (msg_ready !== 1'b1) begin miscompares++; $display("FAIL single.ready_after got %b want 1", msg_ready); end
        credit_in = 1'b1;
        @(negedge clk);
        credit_in = 1'b0;
    endtask

    task automatic test_credit_stall;
        bit          exp_send [7] = '{1, 1, 0, 0, 1, 1, 0};
        bit          exp_tail [7] = '{0, 0, 0, 0, 0, 1, 0};
        int unsigned exp_idx  [7] = '{0, 1, 2, 2, 2, 3, 3};
        msg_data = mk(1); msg_dest = 4'd9; msg_len = 3'd4; msg_valid = 1'b1;
        for (int unsigned c = 1; c <= 7; c++) begin
            @(negedge clk);
            msg_valid = 1'b0;
            credit_in = (c == 4 || c == 5);
            vectors++; if (send_out !== exp_send[c-1]) begin miscompares++; $display("FAIL stall.send[%0d] got %b want %b", c, send_out, exp_send[c-1]); end
            vectors++; if (is_tail_out !== exp_tail[c-1]) begin miscompares++; $display("FAIL stall.tail[%0d] got %b want %b", c, is_tail_out, exp_tail[c-1]); end
            vectors++; if (busy !== (c <= 6)) begin miscompares++; $display("FAIL stall.busy[%0d] got %b want %b", c, busy, (c <= 6)); end
            if (c <= 6) begin
                exp_flit = fv(1, exp_idx[c-1]);
                vectors++; if (data_out !== exp_flit) begin miscompares++; $display("FAIL stall.data[%0d] got %h want %h", c, data_out, exp_flit); end
                vectors++; if (dest_out !== 4'd9) begin miscompares++; $display("FAIL stall.dest[%0d] got %h want 9", c, dest_out); end
            end
        end
        @(negedge clk); credit_in = 1'b1;
        @(negedge clk); credit_in = 1'b1;
        @(negedge clk); credit_in = 1'b0;
    endtask

    task automatic test_back_to_back;
        msg_data = mk(2); msg_dest = 4'd5; msg_len = 3'd2; msg_valid = 1'b1;
        for (int unsigned c = 1; c <= 7; c++) begin
            @(negedge clk);
            credit_in = (c >= 2);
            if (c == 1) begin msg_data = mk(3); msg_dest = 4'd6; end
            if (c == 3) begin msg_data = mk(4); msg_dest = 4'd7; end
            if (c == 5) msg_valid = 1'b0;
            if (c <= 6) begin
                exp_flit = fv(2 + (c-1)/2, (c-1)%2);
                vectors++; if (send_out !== 1'b1) begin miscompares++; $display("FAIL b2b.send[%0d] got %b want 1", c, send_out); end
                vectors++; if (data_out !== exp_flit) begin miscompares++; $display("FAIL b2b.data[%0d] got %h want %h", c, data_out, exp_flit); end
                vectors++; if (dest_out !== 4'(5 + (c-1)/2)) begin miscompares++; $display("FAIL b2b.dest[%0d] got %0d want %0d", c, dest_out, 5 + (c-1)/2); end
                vectors++; if (is_tail_out !== (c%2 == 0)) begin miscompares++; $display("FAIL b2b.tail[%0d] got %b want %b", c, is_tail_out, (c%2 == 0)); end
                vectors++; if (msg_ready !== (c%2 == 0)) begin miscompares++; $display("FAIL b2b.ready[%0d] got %b want %b", c, msg_ready, (c%2 == 0)); end
            end else begin
                vectors++; if (send_out !== 1'b0) begin miscompares++; $display("FAIL b2b.send_end got %b want 0", send_out); end
                vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b.busy_end got %b want 0", busy); end
                vectors++; if (msg_ready !== 1'b1) begin miscompares++; $display("FAIL b2b.ready_end got %b want 1", msg_ready); end
            end
        end
        @(negedge clk);
        credit_in = 1'b0;
    endtask

    task automatic test_simultaneous_overflow;
        msg_data = mk(5); msg_dest = 4'd10; msg_len = 3'd4; msg_valid = 1'b1;
        for (int unsigned c = 1; c <= 9; c++) begin
            @(negedge clk);
            credit_in = (c <= 8);
            if (c == 1) begin msg_data = mk(6); msg_dest = 4'd11; end
            if (c == 5) msg_valid = 1'b0;
            if (c <= 8) begin
                exp_flit = fv(5 + (c-1)/4, (c-1)%4);
                vectors++; if (send_out !== 1'b1) begin miscompares++; $display("FAIL simul.send[%0d] got %b want 1", c, send_out); end
                vectors++; if (data_out !== exp_flit) begin miscompares++; $display("FAIL simul.data[%0d] got %h want %h", c, data_out, exp_flit); end
                vectors++; if (dest_out !== 4'(10 + (c-1)/4)) begin miscompares++; $display("FAIL simul.dest[%0d] got %0d want %0d", c, dest_out, 10 + (c-1)/4); end
                vectors++; if (is_tail_out !== (c%4 == 0)) begin miscompares++; $display("FAIL simul.tail[%0d] got %b want %b", c, is_tail_out, (c%4 == 0)); end
            end else begin
                vectors++; if (send_out !== 1'b0) begin miscompares++; $display("FAIL simul.send_end got %b want 0", send_out); end
                vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL simul.busy_end got %b want 0", busy); end
                vectors++; if (credit_overflow !== 1'b0) begin miscompares++; $display("FAIL simul.ovf_before got %b want 0", credit_overflow); end
            end
        end
        @(negedge clk); credit_in = 1'b1;
        @(negedge clk); credit_in = 1'b0;
        vectors++; if (credit_overflow !== 1'b1) begin miscompares++; $display("FAIL ovf.set got %b want 1", credit_overflow); end
        repeat (3) @(negedge clk);
        vectors++; if (credit_overflow !== 1'b1) begin miscompares++; $display("FAIL ovf.sticky got %b want 1", credit_overflow); end
        vectors++; if (send_out !== 1'b0) begin miscompares++; $display("FAIL ovf.send got %b want 0", send_out); end
        vectors++; if (msg_ready !== 1'b1) begin miscompares++; $display("FAIL ovf.ready got %b want 1", msg_ready); end
    endtask

    task automatic test_reset_mid_and_clamp;
        msg_data = mk(7); msg_dest = 4'd12; msg_len = 3'd4; msg_valid = 1'b1;
        @(negedge clk);
        msg_valid = 1'b0;
        exp_flit = fv(7, 0);
        vectors++; if (data_out !== exp_flit || send_out !== 1'b1) begin miscompares++; $display("FAIL mid.flit0 got %b/%h want 1/%h", send_out, data_out, exp_flit); end
        @(negedge clk);
        exp_flit = fv(7, 1);
        vectors++; if (data_out !== exp_flit || send_out !== 1'b1) begin miscompares++; $display("FAIL mid.flit1 got %b/%h want 1/%h", send_out, data_out, exp_flit); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid.busy got %b want 0", busy); end
        vectors++; if (credit_overflow !== 1'b0) begin miscompares++; $display("FAIL mid.ovf_clear got %b want 0", credit_overflow); end
        vectors++; if (data_out !== '0) begin miscompares++; $display("FAIL mid.data got %h want 0", data_out); end
        for (int unsigned c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++; if (send_out !== 1'b0) begin miscompares++; $display("FAIL mid.no_send[%0d] got %b want 0", c, send_out); end
        end
        // a credit while full must overflow, proving the counter was restored to 2
        credit_in = 1'b1;
        @(negedge clk);
        credit_in = 1'b0;
        vectors++; if (credit_overflow !== 1'b1) begin miscompares++; $display("FAIL mid.credits_full got %b want 1", credit_overflow); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        vectors++; if (credit_overflow !== 1'b0) begin miscompares++; $display("FAIL mid.ovf_reset got %b want 0", credit_overflow); end

        msg_data = mk(8); msg_dest = 4'd1; msg_len = 3'd0; msg_valid = 1'b1;
        @(negedge clk);
        msg_valid = 1'b0; credit_in = 1'b1;
        exp_flit = fv(8, 0);
        vectors++; if (send_out !== 1'b1 || is_tail_out !== 1'b1) begin miscompares++; $display("FAIL len0.send_tail got %b%b want 11", send_out, is_tail_out); end
        vectors++; if (data_out !== exp_flit) begin miscompares++; $display("FAIL len0.data got %h want %h", data_out, exp_flit); end
        @(negedge clk);
        credit_in = 1'b0;
        vectors++; if (send_out !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL len0.done got %b%b want 00", send_out, busy); end

        msg_data = mk(9); msg_dest = 4'd2; msg_len = 3'd7; msg_valid = 1'b1;
        for (int unsigned c = 1; c <= 5; c++) begin
            @(negedge clk);
            msg_valid = 1'b0;
            credit_in = (c <= 4);
            if (c <= 4) begin
                exp_flit = fv(9, c-1);
                vectors++; if (send_out !== 1'b1) begin miscompares++; $display("FAIL len7.send[%0d] got %b want 1", c, send_out); end
                vectors++; if (data_out !== exp_flit) begin miscompares++; $display("FAIL len7.data[%0d] got %h want %h", c, data_out, exp_flit); end
                vectors++; if (is_tail_out !== (c == 4)) begin miscompares++; $display("FAIL len7.tail[%0d] got %b want %b", c, is_tail_out, (c == 4)); end
            end else begin
                vectors++; if (send_out !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL len7.done got %b%b want 00", send_out, busy); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_credit_stall();
        test_back_to_back();
        test_simultaneous_overflow();
        test_reset_mid_and_clamp();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/noc_packetizer.md
# noc_packetizer

Injection-side endpoint adapter that sits directly upstream of one NoC input port (`data_in`/`dest_in`/`is_tail_in`/`send_in`/`credit_out` of one router's local port). It accepts a whole multi-flit message over a valid/ready handshake, then serializes it into flits. It also owns the credit counter that mirrors the router's local input flit buffer, so it never sends a flit the router cannot accept. Back-to-back messages stream without bubbles when credits allow.

## Interface

Parameters:
- `DEST_WIDTH`, 4: destination endpoint ID width.
- `FLIT_WIDTH`, 256: flit payload width.
- `FLIT_BUFFER_DEPTH`, 2: router input buffer depth. This is the initial and maximum credit count.
- `PACKET_FLITS`, 4: maximum flits per message (≥1).

Ports (LW = $clog2(PACKET_FLITS+1), CW = $clog2(FLIT_BUFFER_DEPTH+1)):
- `clk` in 1: single clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `msg_data` in FLIT_WIDTH*PACKET_FLITS: message payload. Flit k is `msg_data[k*FLIT_WIDTH +: FLIT_WIDTH]`, and flit 0 is sent first.
- `msg_dest` in DEST_WIDTH: destination, replicated on every flit.
- `msg_len` in LW: flit count. 0 is treated as 1. Values above PACKET_FLITS are clamped to PACKET_FLITS.
- `msg_valid` in 1: message offered.
- `msg_ready` out 1: message accepted on an edge where `msg_valid && msg_ready`.
- `data_out` out FLIT_WIDTH: flit to router `data_in`.
- `dest_out` out DEST_WIDTH: to router `dest_in`.
- `is_tail_out` out 1: to router `is_tail_in`.
- `send_out` out 1: flit valid this cycle. Drives router `send_in`.
- `credit_in` in 1: one-cycle pulse from router `credit_out`. Each pulse means one buffer slot has been freed.
- `busy` out 1: a message is held (state SEND).
- `credit_overflow` out 1: sticky error flag, set when a credit is returned while the counter is already full.

## Operation

- Registers: `state` ∈ {IDLE, SEND}, message buffer, `dest`, `len`, flit index `idx` (LW bits), `credits` (CW bits), `credit_overflow`.
- `fire` = (state==SEND) && (credits != 0). This is a function of registers only.
- `last` = (idx == len-1).
- All outputs are driven from registers plus `fire`. There is no combinational path from `credit_in`, `msg_valid` or `msg_*` to any output.
  - `send_out` = fire.
  - `data_out` = buffer flit `idx`; `dest_out` = `dest`.
  - `is_tail_out` = fire && last.
  - `busy` = (state==SEND).
- `msg_ready` = (state==IDLE) || (fire && last).
- IDLE:
  - On accept: latch data, dest and effective len; set idx=0; go to SEND.
  - Otherwise stay in IDLE.
- SEND, when fire && !last: idx++.
- SEND, when fire && last:
  - If `msg_valid`, the new message is accepted on the same edge: reload the buffer, idx=0, stay in SEND.
  - Otherwise go to IDLE.
- SEND, when !fire (no credits): hold everything. `send_out` is 0. Flit contents do not change while stalled.
- Credits:
  - next = credits − fire + credit_in.
  - A simultaneous fire and credit_in leaves the count unchanged.
  - If credit_in arrives with credits==FLIT_BUFFER_DEPTH and no fire: saturate at FLIT_BUFFER_DEPTH and set `credit_overflow`, which holds until reset.
- Credits persist across messages. There is no per-packet credit reservation: flits of one packet may be separated by stall cycles, and the router's wormhole switching tolerates this.

## Timing

- Reset (`rst_n` low at an edge) gives, from the next cycle:
  - state=IDLE, idx=0, len=1, buffer=0, dest=0, credits=FLIT_BUFFER_DEPTH, credit_overflow=0.
  - Outputs: `send_out`=0, `is_tail_out`=0, `data_out`=0, `dest_out`=0, `busy`=0, `msg_ready`=1.
- Reset in the middle of a packet discards the remainder with no tail flit. The NoC must be reset in the same cycle.
- Latency: a message accepted at edge E with credits>0 presents flit 0 in the cycle after E. The tail flit follows len−1 cycles later if no credit stall occurs.
- Throughput: with credits never exhausted, one flit per cycle, including across message boundaries (zero-bubble tail-to-head).
- Credit effects:
  - A `credit_in` pulse at edge E makes `send_out` possible in the cycle after E.
  - With 0 credits the minimum stall equals the router's credit return latency.
- At most FLIT_BUFFER_DEPTH flits are ever outstanding, where outstanding = sent − credits returned.

## Test plan

- Reset and idle:
  - Stimulus: hold `rst_n`=0 for 2 cycles, release; msg_valid=0.
  - Required: all outputs at their reset values, credits=2 (visible as two immediate sends later), `msg_ready`=1.
- Single-flit message:
  - Stimulus: msg_len=1, msg_dest=3, flit0=0xA5.
  - Required: exactly one cycle with send_out=1, is_tail_out=1, data_out=0xA5, dest_out=3, one cycle after accept. Returns to IDLE.
- Credit stall:
  - Stimulus: FLIT_BUFFER_DEPTH=2, msg_len=4, no credit_in until 5 cycles after accept, then one pulse per cycle.
  - Required: flits 0 and 1 on consecutive cycles, then send_out=0 while stalled. Flits 2 and 3 follow each credit by one cycle. Only flit 3 has is_tail_out=1.
- Back-to-back streaming:
  - Stimulus: three 2-flit messages held valid continuously; credit_in pulsed the cycle after each send.
  - Required: 6 consecutive send_out cycles. is_tail_out on the 2nd, 4th and 6th. msg_ready high on each tail cycle.
- Simultaneous credit and send, plus overflow:
  - Stimulus: credit_in asserted on every send cycle of an 8-flit stream.
  - Required: the credit count stays at 2 and there are no stalls.
  - Stimulus: then, while idle at credits=2, pulse credit_in.
  - Required: credit_overflow=1 and it stays 1 until reset.
- Reset mid-packet and length clamping:
  - Stimulus: reset asserted after flit 1 of a 4-flit message.
  - Required: no further sends; credits=2 after release.
  - Stimulus: msg_len=0.
  - Required: sent as 1 flit with tail.
  - Stimulus: msg_len=7 with PACKET_FLITS=4.
  - Required: sent as 4 flits.
